// File: rtl/dmem_pkg.sv
// Shared types for the dual-lane data-memory responder: request/response records,
// FSM states, lane count and the misalignment rule.
package dmem_pkg;

    localparam int LANES = 2;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_e;

    typedef struct packed {
        logic        valid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } DMEM_REQ;

    typedef struct packed {
        logic        valid;
        logic [31:0] rdata;
        logic        err;
    } DMEM_RESP;

    // Loads and full-word stores need word alignment; halfword stores need halfword alignment.
    function automatic logic isMisaligned(input logic we, input logic [1:0] addrLo, input logic [3:0] be);
        logic wordSized;
        logic halfSized;
        wordSized = !we || (be == 4'b1111);
        halfSized = we && ((be == 4'b0011) || (be == 4'b1100));
        return (wordSized && (addrLo != 2'b00)) || (halfSized && addrLo[0]);
    endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Two-lane request/response bundle between the memory stage (master) and the responder (slave).
interface dmem_responder_if;
    import dmem_pkg::*;

    logic [LANES-1:0]       req_valid;
    logic [LANES-1:0]       req_we;
    logic [LANES-1:0][31:0] req_addr;
    logic [LANES-1:0][31:0] req_wdata;
    logic [LANES-1:0][3:0]  req_be;
    logic [LANES-1:0]       resp_valid;
    logic [LANES-1:0][31:0] resp_rdata;
    logic [LANES-1:0]       resp_err;
    logic                   stall_from_memory;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be,
        input  resp_valid, resp_rdata, resp_err, stall_from_memory
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be,
        output resp_valid, resp_rdata, resp_err, stall_from_memory
    );

endinterface

// File: rtl/dmem_array.sv
// Single-port byte-enabled word RAM; read data appears READ_LATENCY clocks after the address.
// Read and write share the address, and a read during a write returns the old word.
module dmem_array #(
    parameter int DEPTH_LOG2   = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic                  clk,
    input  logic [DEPTH_LOG2-1:0] i_addr,
    input  logic                  i_we,
    input  logic [3:0]            i_be,
    input  logic [31:0]           i_wdata,
    output logic [31:0]           o_rdata
);

    logic [31:0] r_mem  [2**DEPTH_LOG2];
    logic [31:0] r_pipe [READ_LATENCY];

    always_ff @(posedge clk) begin
        if (i_we) begin
            for (int b = 0; b < 4; b++) begin
                if (i_be[b]) begin
                    r_mem[i_addr][8*b +: 8] <= i_wdata[8*b +: 8];
                end
            end
        end
        r_pipe[0] <= r_mem[i_addr];
        for (int s = 1; s < READ_LATENCY; s++) begin
            r_pipe[s] <= r_pipe[s-1];
        end
    end

    assign o_rdata = r_pipe[READ_LATENCY-1];

endmodule

// File: rtl/dmem_responder.sv
// Serialises up to two load/store lanes onto dmem_array, stalling the pipeline until both finish.
// Define DMEM_ALIGN_CHECK_EN to flag and suppress misaligned accesses via resp_err.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_LOG2   = 10,
    parameter int READ_LATENCY = 1
) (
    input  logic            clk,
    input  logic            rst,
    dmem_responder_if.slave bus
);

    localparam logic [1:0] CNT_INIT = 2'(READ_LATENCY - 1);

    state_e                 r_state;
    state_e                 w_nextState;
    DMEM_REQ [LANES-1:0]    r_req;
    DMEM_REQ [LANES-1:0]    w_inReq;
    DMEM_REQ                w_curReq;
    DMEM_RESP [LANES-1:0]   w_resp;
    logic                   r_cur;
    logic                   w_nextCur;
    logic [1:0]             r_cnt;
    logic [1:0]             w_nextCnt;
    logic [LANES-1:0][31:0] r_rdata;
    logic [LANES-1:0]       r_err;
    logic [LANES-1:0]       w_inErr;
    logic                   r_capPend;
    logic                   r_capLane;
    logic                   w_capture;
    logic                   w_loadDone;
    logic                   w_memWe;
    logic                   w_stall;
    logic [31:0]            w_memRdata;
    logic                   w_unusedBits;

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_inReq[l].valid = bus.req_valid[l];
            w_inReq[l].we    = bus.req_we[l];
            w_inReq[l].addr  = bus.req_addr[l];
            w_inReq[l].wdata = bus.req_wdata[l];
            w_inReq[l].be    = bus.req_be[l];
        end
    end

    always_comb begin
        w_inErr = '0;
`ifdef DMEM_ALIGN_CHECK_EN
        for (int l = 0; l < LANES; l++) begin
            w_inErr[l] = bus.req_valid[l] &
                         isMisaligned(bus.req_we[l], bus.req_addr[l][1:0], bus.req_be[l]);
        end
`endif
    end

    assign w_curReq     = r_req[r_cur];
    assign w_unusedBits = ^r_req;

    always_comb begin
        w_nextState = r_state;
        w_nextCur   = r_cur;
        w_nextCnt   = r_cnt;
        w_capture   = 1'b0;
        w_loadDone  = 1'b0;
        w_memWe     = 1'b0;
        w_stall     = 1'b0;
        case (r_state)
            IDLE: begin
                w_stall = |bus.req_valid;
                if (|bus.req_valid) begin
                    w_capture   = 1'b1;
                    w_nextCur   = ~bus.req_valid[0];
                    w_nextCnt   = CNT_INIT;
                    w_nextState = BUSY;
                end
            end
            BUSY: begin
                w_stall = 1'b1;
                if (r_cnt != 2'd0) begin
                    w_nextCnt = r_cnt - 2'd1;
                end else begin
                    w_memWe    = w_curReq.we & ~r_err[r_cur];
                    w_loadDone = ~w_curReq.we;
                    if (r_req[1].valid && !r_cur) begin
                        w_nextCur = 1'b1;
                        w_nextCnt = CNT_INIT;
                    end else begin
                        w_nextState = RESP;
                    end
                end
            end
            RESP: begin
                w_nextState = IDLE;
            end
            default: begin
                w_nextState = IDLE;
            end
        endcase
    end

    // A load's word leaves the array one cycle after its last access cycle, so it is latched then.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_cur     <= 1'b0;
            r_cnt     <= 2'd0;
            r_req     <= '0;
            r_rdata   <= '0;
            r_err     <= '0;
            r_capPend <= 1'b0;
            r_capLane <= 1'b0;
        end else begin
            r_state   <= w_nextState;
            r_cur     <= w_nextCur;
            r_cnt     <= w_nextCnt;
            r_capPend <= w_loadDone;
            r_capLane <= r_cur;
            if (w_capture) begin
                r_req   <= w_inReq;
                r_rdata <= '0;
                r_err   <= w_inErr;
            end
            if (r_capPend) begin
                r_rdata[r_capLane] <= r_err[r_capLane] ? 32'd0 : w_memRdata;
            end
        end
    end

    dmem_array #(
        .DEPTH_LOG2  (DEPTH_LOG2),
        .READ_LATENCY(READ_LATENCY)
    ) u_array (
        .clk    (clk),
        .i_addr (w_curReq.addr[DEPTH_LOG2+1:2]),
        .i_we   (w_memWe),
        .i_be   (w_curReq.be),
        .i_wdata(w_curReq.wdata),
        .o_rdata(w_memRdata)
    );

    // The last lane's load word is still on the array output during RESP, so it bypasses the register.
    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            w_resp[l] = '0;
            if (r_state == RESP) begin
                w_resp[l].valid = r_req[l].valid;
                w_resp[l].err   = r_err[l];
                if (r_capPend && (r_capLane == 1'(l))) begin
                    w_resp[l].rdata = r_err[l] ? 32'd0 : w_memRdata;
                end else begin
                    w_resp[l].rdata = r_rdata[l];
                end
            end
        end
    end

    always_comb begin
        for (int l = 0; l < LANES; l++) begin
            bus.resp_valid[l] = w_resp[l].valid;
            bus.resp_rdata[l] = w_resp[l].rdata;
            bus.resp_err[l]   = w_resp[l].err;
        end
        bus.stall_from_memory = w_stall & ~rst;
    end

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder at read latency 1 and 3: directed vector table, reset sequences and
// randomized groups checked against a lane-ordered memory model (honours DMEM_ALIGN_CHECK_EN).
module tb_dmem_responder;

    typedef struct {
        int              sel;
        logic [1:0]      valid;
        logic [1:0]      we;
        logic [1:0][31:0] addr;
        logic [1:0][31:0] wdata;
        logic [1:0][3:0]  be;
        logic [1:0][31:0] expRdata;
        logic [1:0]      expErr;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    int   curSel;
    int   checks;
    int   fails;
    logic [31:0] modelMem [2][1024];

    always #5 clk = ~clk;

    dmem_responder_if bus1 ();
    dmem_responder_if bus3 ();

    dmem_responder #(.DEPTH_LOG2(10), .READ_LATENCY(1)) u_dutLat1 (.clk(clk), .rst(rst), .bus(bus1));
    dmem_responder #(.DEPTH_LOG2(10), .READ_LATENCY(3)) u_dutLat3 (.clk(clk), .rst(rst), .bus(bus3));

    logic [1:0]       obsValid;
    logic [1:0][31:0] obsRdata;
    logic [1:0]       obsErr;
    logic             obsStall;

    assign obsValid = (curSel == 0) ? bus1.resp_valid : bus3.resp_valid;
    assign obsRdata = (curSel == 0) ? bus1.resp_rdata : bus3.resp_rdata;
    assign obsErr   = (curSel == 0) ? bus1.resp_err   : bus3.resp_err;
    assign obsStall = (curSel == 0) ? bus1.stall_from_memory : bus3.stall_from_memory;

    task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic vec_t makeVec(input int sel, input logic [1:0] valid, input logic [1:0] we,
                                     input logic [31:0] a0, input logic [31:0] a1,
                                     input logic [31:0] d0, input logic [31:0] d1,
                                     input logic [3:0] be0, input logic [3:0] be1,
                                     input logic [31:0] r0, input logic [31:0] r1,
                                     input logic [1:0] err);
        vec_t v;
        v.sel = sel;   v.valid = valid; v.we = we;
        v.addr[0] = a0;  v.addr[1] = a1;
        v.wdata[0] = d0; v.wdata[1] = d1;
        v.be[0] = be0;   v.be[1] = be1;
        v.expRdata[0] = r0; v.expRdata[1] = r1;
        v.expErr = err;
        return v;
    endfunction

    task automatic clearBus();
        bus1.req_valid = '0; bus1.req_we = '0; bus1.req_addr = '0; bus1.req_wdata = '0; bus1.req_be = '0;
        bus3.req_valid = '0; bus3.req_we = '0; bus3.req_addr = '0; bus3.req_wdata = '0; bus3.req_be = '0;
    endtask

    task automatic driveBus(input vec_t v);
        curSel = v.sel;
        bus1.req_valid = (v.sel == 0) ? v.valid : 2'b00;
        bus3.req_valid = (v.sel == 1) ? v.valid : 2'b00;
        bus1.req_we = v.we;       bus3.req_we = v.we;
        bus1.req_addr = v.addr;   bus3.req_addr = v.addr;
        bus1.req_wdata = v.wdata; bus3.req_wdata = v.wdata;
        bus1.req_be = v.be;       bus3.req_be = v.be;
    endtask

    // Drives one group and counts stall cycles until the response pulse (bounded).
    task automatic applyStimulus(input vec_t v, output int stallCycles, output bit gotResp);
        int cyc;
        @(negedge clk);
        driveBus(v);
        #1;
        stallCycles = 0;
        gotResp = 1'b0;
        cyc = 0;
        while (!gotResp && cyc < 40) begin
            if (obsValid != 2'b00) begin
                gotResp = 1'b1;
            end else begin
                if (obsStall) stallCycles++;
                @(negedge clk);
                #1;
                cyc++;
            end
        end
    endtask

    task automatic checkOutput(input vec_t v, input int stallCycles, input bit gotResp);
        int lat;
        lat = (v.sel == 0) ? 1 : 3;
        checkEq("respSeen", 32'(gotResp), 32'd1);
        if (gotResp) begin
            checkEq("respValid", 32'(obsValid), 32'(v.valid));
            checkEq("stallCycles", 32'(stallCycles), 32'(1 + $countones(v.valid) * lat));
            checkEq("stallInResp", 32'(obsStall), 32'd0);
            checkEq("respErr", 32'(obsErr), 32'(v.expErr));
            for (int l = 0; l < 2; l++) begin
                if (v.valid[l]) checkEq($sformatf("rdata%0d", l), obsRdata[l], v.expRdata[l]);
            end
        end
        clearBus();
        @(negedge clk);
        #1;
        checkEq("respPulseEnd", 32'(obsValid), 32'd0);
    endtask

    function automatic logic modelMisaligned(input logic we, input logic [31:0] addr, input logic [3:0] be);
`ifdef DMEM_ALIGN_CHECK_EN
        if (!we || be == 4'hF) return (addr % 4) != 0;
        if (be == 4'b0011 || be == 4'b1100) return (addr % 2) != 0;
        return 1'b0;
`else
        return 1'b0;
`endif
    endfunction

    // Lane 0 then lane 1 against a plain word array indexed modulo the depth.
    task automatic modelGroup(inout vec_t v);
        int idx;
        v.expErr = '0;
        v.expRdata = '0;
        for (int l = 0; l < 2; l++) begin
            if (v.valid[l]) begin
                idx = int'((v.addr[l] / 4) % 1024);
                v.expErr[l] = modelMisaligned(v.we[l], v.addr[l], v.be[l]);
                if (v.we[l]) begin
                    if (!v.expErr[l]) begin
                        for (int b = 0; b < 4; b++)
                            if (v.be[l][b]) modelMem[v.sel][idx][8*b +: 8] = v.wdata[l][8*b +: 8];
                    end
                end else begin
                    v.expRdata[l] = v.expErr[l] ? 32'd0 : modelMem[v.sel][idx];
                end
            end
        end
    endtask

    task automatic randomGroup(input int sel, input bit initPhase, input int k);
        vec_t v;
        int   sc;
        bit   got;
        int   idx;
        int   lo;
        v = makeVec(sel, 2'b00, 2'b00, 0, 0, 0, 0, 4'h0, 4'h0, 0, 0, 2'b00);
        v.valid = initPhase ? 2'b11 : 2'($urandom_range(1, 3));
        for (int l = 0; l < 2; l++) begin
            if (initPhase) begin
                v.we[l] = 1'b1; idx = 64 + 2*k + l; lo = 0; v.be[l] = 4'hF;
            end else begin
                v.we[l] = 1'($urandom); idx = 64 + $urandom_range(0, 15); lo = $urandom_range(0, 3);
                v.be[l] = 4'($urandom);
            end
            v.addr[l]  = {20'($urandom), 10'(idx), 2'(lo)};
            v.wdata[l] = $urandom;
        end
        modelGroup(v);
        applyStimulus(v, sc, got);
        checkOutput(v, sc, got);
    endtask

    vec_t dirVec[13];

    initial begin
        int   sc;
        bit   got;
        bit   sawResp;
        vec_t v;
        checks = 0;
        fails  = 0;
        curSel = 0;
        rst    = 1'b1;
        clearBus();

        // Reset state, with requests present to show stall is held low.
        bus1.req_valid = 2'b11; bus3.req_valid = 2'b11;
        repeat (2) @(negedge clk);
        #1;
        checkEq("rstStallL1", 32'(bus1.stall_from_memory), 32'd0);
        checkEq("rstStallL3", 32'(bus3.stall_from_memory), 32'd0);
        checkEq("rstValidL1", 32'(bus1.resp_valid), 32'd0);
        checkEq("rstValidL3", 32'(bus3.resp_valid), 32'd0);
        checkEq("rstRdata0", bus1.resp_rdata[0], 32'd0);
        checkEq("rstErrL1", 32'(bus1.resp_err), 32'd0);
        clearBus();
        @(negedge clk);
        rst = 1'b0;

        dirVec[0]  = makeVec(0, 2'b11, 2'b11, 32'h10, 32'h20, 32'hDEADBEEF, 32'h11223344, 4'hF, 4'hF, 0, 0, 2'b00);
        dirVec[1]  = makeVec(0, 2'b01, 2'b00, 32'h10, 32'h0, 0, 0, 4'h0, 4'h0, 32'hDEADBEEF, 0, 2'b00);
        dirVec[2]  = makeVec(0, 2'b11, 2'b01, 32'h20, 32'h20, 32'hAABBCCDD, 0, 4'b0011, 4'h0, 0, 32'h1122CCDD, 2'b00);
        dirVec[3]  = makeVec(0, 2'b01, 2'b01, 32'h1004, 32'h0, 32'h5, 0, 4'hF, 4'h0, 0, 0, 2'b00);
        dirVec[4]  = makeVec(0, 2'b01, 2'b00, 32'h0004, 32'h0, 0, 0, 4'h0, 4'h0, 32'h00000005, 0, 2'b00);
        dirVec[5]  = makeVec(0, 2'b11, 2'b01, 32'h10, 32'h10, 32'h0, 0, 4'h0, 4'h0, 0, 32'hDEADBEEF, 2'b00);
        dirVec[6]  = makeVec(0, 2'b10, 2'b00, 32'h0, 32'h20, 0, 0, 4'h0, 4'h0, 0, 32'h1122CCDD, 2'b00);
`ifdef DMEM_ALIGN_CHECK_EN
        dirVec[7]  = makeVec(0, 2'b01, 2'b00, 32'h22, 32'h0, 0, 0, 4'h0, 4'h0, 32'h0, 0, 2'b01);
`else
        dirVec[7]  = makeVec(0, 2'b01, 2'b00, 32'h22, 32'h0, 0, 0, 4'h0, 4'h0, 32'h1122CCDD, 0, 2'b00);
`endif
        dirVec[8]  = makeVec(0, 2'b01, 2'b00, 32'h20, 32'h0, 0, 0, 4'h0, 4'h0, 32'h1122CCDD, 0, 2'b00);
        dirVec[9]  = makeVec(1, 2'b11, 2'b11, 32'h40, 32'h44, 32'h01020304, 32'hA5A5A5A5, 4'hF, 4'hF, 0, 0, 2'b00);
        dirVec[10] = makeVec(1, 2'b11, 2'b00, 32'h40, 32'h44, 0, 0, 4'h0, 4'h0, 32'h01020304, 32'hA5A5A5A5, 2'b00);
        dirVec[11] = makeVec(1, 2'b11, 2'b01, 32'h40, 32'h40, 32'hFFEE0000, 0, 4'b1100, 4'h0, 0, 32'hFFEE0304, 2'b00);
        dirVec[12] = makeVec(1, 2'b11, 2'b11, 32'h50, 32'h54, 32'h0, 32'h12345678, 4'hF, 4'hF, 0, 0, 2'b00);

        for (int i = 0; i < 13; i++) begin
            applyStimulus(dirVec[i], sc, got);
            checkOutput(dirVec[i], sc, got);
        end

        // Reset while lane 1 of a latency-3 group is in flight; lane 0 store already done.
        v = makeVec(1, 2'b11, 2'b11, 32'h50, 32'h54, 32'hCAFEF00D, 32'h0, 4'hF, 4'hF, 0, 0, 2'b00);
        @(negedge clk);
        driveBus(v);
        repeat (5) @(negedge clk);
        #1;
        checkEq("stallBeforeReset", 32'(obsStall), 32'd1);
        rst = 1'b1;
        #1;
        checkEq("stallInReset", 32'(obsStall), 32'd0);
        @(negedge clk);
        clearBus();
        @(negedge clk);
        rst = 1'b0;
        sawResp = 1'b0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            #1;
            if (obsValid != 2'b00) sawResp = 1'b1;
        end
        checkEq("noRespAfterReset", 32'(sawResp), 32'd0);
        v = makeVec(1, 2'b11, 2'b00, 32'h50, 32'h54, 0, 0, 4'h0, 4'h0, 32'hCAFEF00D, 32'h12345678, 2'b00);
        applyStimulus(v, sc, got);
        checkOutput(v, sc, got);

        // Randomized groups over a preloaded 16-word region, both latencies.
        for (int s = 0; s < 2; s++) begin
            for (int k = 0; k < 8; k++) randomGroup(s, 1'b1, k);
            for (int n = 0; n < 25; n++) begin
                if (n % 5 == 0) begin
                    @(negedge clk);
                    curSel = s;
                    #1;
                    checkEq("idleStall", 32'(obsStall), 32'd0);
                end
                randomGroup(s, 1'b0, 0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
